// File: rtl/reorder_buffer_if.sv
// Signal bundle between the reorder buffer and its neighbours: decoder issue/query,
// RS/ALU and LSB broadcast buses, and the commit/flush outputs.
interface reorder_buffer_if #(
    parameter int W = 3
);
    logic          rob_full;
    logic [W-1:0]  tail_rob_id;
    logic          instr_issued;
    logic [6:0]    instr_type_in;
    logic [4:0]    rd_in;
    logic          pred_taken_in;
    logic [31:0]   alt_pc_in;
    logic          rs_ready;
    logic [W-1:0]  rs_rob_id;
    logic [31:0]   rs_value;
    logic          lsb_ready;
    logic [W-1:0]  lsb_rob_id;
    logic [31:0]   lsb_value;
    logic [W-1:0]  query1_id;
    logic [W-1:0]  query2_id;
    logic          query1_ready;
    logic          query2_ready;
    logic [31:0]   query1_value;
    logic [31:0]   query2_value;
    logic          commit_valid;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_value;
    logic [W-1:0]  commit_rob_id;
    logic          commit_store;
    logic          rob_clear;
    logic [31:0]   redirect_pc;

    modport master (
        output instr_issued, instr_type_in, rd_in, pred_taken_in, alt_pc_in,
        output rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
        output query1_id, query2_id,
        input  rob_full, tail_rob_id, query1_ready, query2_ready, query1_value, query2_value,
        input  commit_valid, commit_rd, commit_value, commit_rob_id, commit_store,
        input  rob_clear, redirect_pc
    );

    modport slave (
        input  instr_issued, instr_type_in, rd_in, pred_taken_in, alt_pc_in,
        input  rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
        input  query1_id, query2_id,
        output rob_full, tail_rob_id, query1_ready, query2_ready, query1_value, query2_value,
        output commit_valid, commit_rd, commit_value, commit_rob_id, commit_store,
        output rob_clear, redirect_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates RoB ids, captures broadcast results,
// retires the head entry and flushes the pipeline on a branch misprediction.
module reorder_buffer #(
    parameter int ROB_SIZE_WIDTH = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    reorder_buffer_if.slave rob
);
    localparam int         W          = ROB_SIZE_WIDTH;
    localparam int         DEPTH      = 1 << W;
    localparam logic [W:0] FULL_COUNT = {1'b1, {W{1'b0}}};
    localparam logic [6:0] B_TYPE     = 7'b1100011;
    localparam logic [6:0] S_TYPE     = 7'b0100011;

    logic          busy_q  [DEPTH];
    logic          busy_d  [DEPTH];
    logic          ready_q [DEPTH];
    logic          ready_d [DEPTH];
    logic [6:0]    type_q  [DEPTH];
    logic [6:0]    type_d  [DEPTH];
    logic [4:0]    rd_q    [DEPTH];
    logic [4:0]    rd_d    [DEPTH];
    logic [31:0]   value_q [DEPTH];
    logic [31:0]   value_d [DEPTH];
    logic          pred_q  [DEPTH];
    logic          pred_d  [DEPTH];
    logic [31:0]   alt_q   [DEPTH];
    logic [31:0]   alt_d   [DEPTH];

    logic [W-1:0]  head_q, head_d;
    logic [W-1:0]  tail_q, tail_d;
    logic [W:0]    count_q, count_d;

    logic          commit_valid_q, commit_valid_d;
    logic [4:0]    commit_rd_q, commit_rd_d;
    logic [31:0]   commit_value_q, commit_value_d;
    logic [W-1:0]  commit_rob_id_q, commit_rob_id_d;
    logic          commit_store_q, commit_store_d;
    logic          rob_clear_q, rob_clear_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;

    logic          rob_full_s;
    logic          issue_s;
    logic          commit_s;
    logic          head_is_branch_s;
    logic          head_is_store_s;
    logic          mispredict_s;

    // A result on a broadcast bus this cycle beats the stored copy; LSB has priority.
    function automatic logic [32:0] forward_lookup(
        input logic [W-1:0] id,
        input logic         stored_ready,
        input logic [31:0]  stored_value,
        input logic         lsb_rdy,
        input logic [W-1:0] lsb_id,
        input logic [31:0]  lsb_val,
        input logic         rs_rdy,
        input logic [W-1:0] rs_id,
        input logic [31:0]  rs_val
    );
        logic [32:0] res;
        if (lsb_rdy && (lsb_id == id)) begin
            res = {1'b1, lsb_val};
        end else if (rs_rdy && (rs_id == id)) begin
            res = {1'b1, rs_val};
        end else begin
            res = {stored_ready, stored_value};
        end
        return res;
    endfunction

    assign rob_full_s       = (count_q == FULL_COUNT);
    assign head_is_branch_s = (type_q[head_q] == B_TYPE);
    assign head_is_store_s  = (type_q[head_q] == S_TYPE);
    assign commit_s         = rdy & busy_q[head_q] & ready_q[head_q];
    assign mispredict_s     = commit_s & head_is_branch_s & (value_q[head_q][0] != pred_q[head_q]);
    assign issue_s          = rdy & rob.instr_issued & ~rob_full_s & ~mispredict_s;

    // Next state: writebacks, then issue, then retirement; a mispredict flushes everything.
    always_comb begin
        busy_d          = busy_q;
        ready_d         = ready_q;
        type_d          = type_q;
        rd_d            = rd_q;
        value_d         = value_q;
        pred_d          = pred_q;
        alt_d           = alt_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        commit_valid_d  = 1'b0;
        commit_store_d  = 1'b0;
        rob_clear_d     = 1'b0;
        commit_rd_d     = commit_rd_q;
        commit_value_d  = commit_value_q;
        commit_rob_id_d = commit_rob_id_q;
        redirect_pc_d   = redirect_pc_q;
        if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && rob.lsb_ready && (rob.lsb_rob_id == W'(i))) begin
                    value_d[i] = rob.lsb_value;
                    ready_d[i] = 1'b1;
                end else if (busy_q[i] && rob.rs_ready && (rob.rs_rob_id == W'(i))) begin
                    value_d[i] = rob.rs_value;
                    ready_d[i] = 1'b1;
                end else begin
                    value_d[i] = value_q[i];
                    ready_d[i] = ready_q[i];
                end
            end
            if (issue_s) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = (rob.instr_type_in == S_TYPE);
                type_d[tail_q]  = rob.instr_type_in;
                rd_d[tail_q]    = rob.rd_in;
                value_d[tail_q] = 32'h0000_0000;
                pred_d[tail_q]  = rob.pred_taken_in;
                alt_d[tail_q]   = rob.alt_pc_in;
                tail_d          = tail_q + 1'b1;
            end else begin
                tail_d = tail_q;
            end
            if (commit_s) begin
                busy_d[head_q]  = 1'b0;
                head_d          = head_q + 1'b1;
                commit_valid_d  = 1'b1;
                commit_value_d  = value_q[head_q];
                commit_rob_id_d = head_q;
                commit_store_d  = head_is_store_s;
                commit_rd_d     = (head_is_branch_s || head_is_store_s) ? 5'd0 : rd_q[head_q];
            end else begin
                head_d = head_q;
            end
            count_d = count_q + {{W{1'b0}}, issue_s} - {{W{1'b0}}, commit_s};
            if (mispredict_s) begin
                for (int i = 0; i < DEPTH; i++) begin
                    busy_d[i]  = 1'b0;
                    ready_d[i] = 1'b0;
                end
                head_d        = {W{1'b0}};
                tail_d        = {W{1'b0}};
                count_d       = {(W+1){1'b0}};
                rob_clear_d   = 1'b1;
                redirect_pc_d = alt_q[head_q];
            end else begin
                rob_clear_d = 1'b0;
            end
        end else begin
            commit_valid_d = 1'b0;
            commit_store_d = 1'b0;
            rob_clear_d    = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
                type_q[i]  <= 7'd0;
                rd_q[i]    <= 5'd0;
                value_q[i] <= 32'h0000_0000;
                pred_q[i]  <= 1'b0;
                alt_q[i]   <= 32'h0000_0000;
            end
            head_q          <= {W{1'b0}};
            tail_q          <= {W{1'b0}};
            count_q         <= {(W+1){1'b0}};
            commit_valid_q  <= 1'b0;
            commit_rd_q     <= 5'd0;
            commit_value_q  <= 32'h0000_0000;
            commit_rob_id_q <= {W{1'b0}};
            commit_store_q  <= 1'b0;
            rob_clear_q     <= 1'b0;
            redirect_pc_q   <= 32'h0000_0000;
        end else begin
            busy_q          <= busy_d;
            ready_q         <= ready_d;
            type_q          <= type_d;
            rd_q            <= rd_d;
            value_q         <= value_d;
            pred_q          <= pred_d;
            alt_q           <= alt_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_valid_q  <= commit_valid_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
            commit_rob_id_q <= commit_rob_id_d;
            commit_store_q  <= commit_store_d;
            rob_clear_q     <= rob_clear_d;
            redirect_pc_q   <= redirect_pc_d;
        end
    end

    assign rob.rob_full      = rob_full_s;
    assign rob.tail_rob_id   = tail_q;
    assign rob.commit_valid  = commit_valid_q;
    assign rob.commit_rd     = commit_rd_q;
    assign rob.commit_value  = commit_value_q;
    assign rob.commit_rob_id = commit_rob_id_q;
    assign rob.commit_store  = commit_store_q;
    assign rob.rob_clear     = rob_clear_q;
    assign rob.redirect_pc   = redirect_pc_q;

    assign {rob.query1_ready, rob.query1_value} = forward_lookup(
        rob.query1_id, ready_q[rob.query1_id], value_q[rob.query1_id],
        rob.lsb_ready, rob.lsb_rob_id, rob.lsb_value,
        rob.rs_ready, rob.rs_rob_id, rob.rs_value);
    assign {rob.query2_ready, rob.query2_value} = forward_lookup(
        rob.query2_id, ready_q[rob.query2_id], value_q[rob.query2_id],
        rob.lsb_ready, rob.lsb_rob_id, rob.lsb_value,
        rob.rs_ready, rob.rs_rob_id, rob.rs_value);
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based model of the retirement rules.
module tb_reorder_buffer;
    localparam int         W     = 3;
    localparam int         DEPTH = 8;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_S   = 7'b0100011;
    localparam logic [6:0] T_B   = 7'b1100011;
    localparam logic [6:0] T_L   = 7'b0000011;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    reorder_buffer_if #(.W(W)) bus ();
    reorder_buffer #(.ROB_SIZE_WIDTH(W)) dut (.clk(clk), .rst(rst), .rdy(rdy), .rob(bus));

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [6:0] typ;
        logic [4:0] rd;
        logic       pred;
        logic [31:0] alt;
    } ent_t;

    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        store;
        logic        clr;
        logic [31:0] rpc;
    } log_t;

    ent_t        mq[$];
    logic        m_ready [DEPTH];
    logic [31:0] m_value [DEPTH];
    int          m_tail;
    logic        e_cv, e_store, e_clear;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_rpc;
    int          e_id;
    log_t        dlog[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_ready[i] = 1'b0;
            m_value[i] = 32'h0;
        end
        m_tail = 0;
        e_cv = 1'b0; e_store = 1'b0; e_clear = 1'b0;
        e_rd = 5'd0; e_val = 32'h0; e_rpc = 32'h0; e_id = 0;
    endfunction

    function automatic bit is_live(int id);
        foreach (mq[k]) if (mq[k].id == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [32:0] exp_query(int qid);
        if (bus.lsb_ready && (int'(bus.lsb_rob_id) == qid)) return {1'b1, bus.lsb_value};
        if (bus.rs_ready && (int'(bus.rs_rob_id) == qid)) return {1'b1, bus.rs_value};
        return {m_ready[qid], m_value[qid]};
    endfunction

    // Advance the model across the coming clock edge using the inputs now driven.
    function automatic void model_step();
        ent_t h;
        bit   do_commit;
        bit   mis;
        e_cv = 1'b0; e_store = 1'b0; e_clear = 1'b0;
        if (rdy) begin
            do_commit = (mq.size() > 0) && m_ready[mq[0].id];
            mis = 1'b0;
            if (do_commit) begin
                h       = mq[0];
                e_cv    = 1'b1;
                e_id    = h.id;
                e_val   = m_value[h.id];
                e_store = (h.typ == T_S);
                e_rd    = (h.typ == T_S || h.typ == T_B) ? 5'd0 : h.rd;
                mis     = (h.typ == T_B) && (m_value[h.id][0] != h.pred);
            end
            if (bus.rs_ready && is_live(int'(bus.rs_rob_id))) begin
                m_value[bus.rs_rob_id] = bus.rs_value;
                m_ready[bus.rs_rob_id] = 1'b1;
            end
            if (bus.lsb_ready && is_live(int'(bus.lsb_rob_id))) begin
                m_value[bus.lsb_rob_id] = bus.lsb_value;
                m_ready[bus.lsb_rob_id] = 1'b1;
            end
            if (bus.instr_issued && mq.size() < DEPTH && !mis) begin
                mq.push_back('{m_tail, bus.instr_type_in, bus.rd_in, bus.pred_taken_in, bus.alt_pc_in});
                m_ready[m_tail] = (bus.instr_type_in == T_S);
                m_value[m_tail] = 32'h0;
                m_tail = (m_tail + 1) % DEPTH;
            end
            if (do_commit) void'(mq.pop_front());
            if (mis) begin
                mq.delete();
                for (int i = 0; i < DEPTH; i++) m_ready[i] = 1'b0;
                m_tail  = 0;
                e_clear = 1'b1;
                e_rpc   = h.alt;
            end
        end
    endfunction

    task automatic check_outputs();
        logic [32:0] q;
        chk("rob_full", 32'(bus.rob_full), 32'(mq.size() == DEPTH));
        chk("tail_rob_id", 32'(bus.tail_rob_id), 32'(m_tail));
        q = exp_query(int'(bus.query1_id));
        chk("query1_ready", 32'(bus.query1_ready), 32'(q[32]));
        chk("query1_value", bus.query1_value, q[31:0]);
        q = exp_query(int'(bus.query2_id));
        chk("query2_ready", 32'(bus.query2_ready), 32'(q[32]));
        chk("query2_value", bus.query2_value, q[31:0]);
        chk("commit_valid", 32'(bus.commit_valid), 32'(e_cv));
        chk("commit_store", 32'(bus.commit_store), 32'(e_store));
        chk("rob_clear", 32'(bus.rob_clear), 32'(e_clear));
        if (e_cv) begin
            chk("commit_rd", 32'(bus.commit_rd), 32'(e_rd));
            chk("commit_value", bus.commit_value, e_val);
            chk("commit_rob_id", 32'(bus.commit_rob_id), 32'(e_id));
        end
        if (e_clear) chk("redirect_pc", bus.redirect_pc, e_rpc);
        if (bus.commit_valid === 1'b1)
            dlog.push_back('{int'(bus.commit_rob_id), bus.commit_rd, bus.commit_value,
                             bus.commit_store, bus.rob_clear, bus.redirect_pc});
    endtask

    task automatic set_idle();
        bus.instr_issued  = 1'b0;
        bus.instr_type_in = 7'd0;
        bus.rd_in         = 5'd0;
        bus.pred_taken_in = 1'b0;
        bus.alt_pc_in     = 32'h0;
        bus.rs_ready      = 1'b0;
        bus.rs_rob_id     = 3'd0;
        bus.rs_value      = 32'h0;
        bus.lsb_ready     = 1'b0;
        bus.lsb_rob_id    = 3'd0;
        bus.lsb_value     = 32'h0;
        bus.query1_id     = W'($urandom_range(0, DEPTH - 1));
        bus.query2_id     = W'($urandom_range(0, DEPTH - 1));
    endtask

    // One clock: check outputs just after the falling edge, update the model, cross the edge.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
        set_idle();
    endtask

    task automatic issue(logic [6:0] typ, logic [4:0] rd, logic pred, logic [31:0] alt);
        bus.instr_issued  = 1'b1;
        bus.instr_type_in = typ;
        bus.rd_in         = rd;
        bus.pred_taken_in = pred;
        bus.alt_pc_in     = alt;
    endtask

    task automatic wb_rs(int id, logic [31:0] v);
        bus.rs_ready = 1'b1; bus.rs_rob_id = W'(id); bus.rs_value = v;
    endtask

    task automatic wb_lsb(int id, logic [31:0] v);
        bus.lsb_ready = 1'b1; bus.lsb_rob_id = W'(id); bus.lsb_value = v;
    endtask

    task automatic do_reset();
        set_idle();
        #2 rst = 1'b0;
        #1 model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        dlog.delete();
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        set_idle();
        model_reset();
        @(negedge clk);
        #1;
        check_outputs();
        chk("reset_tail", 32'(bus.tail_rob_id), 32'd0);
        chk("reset_cv", 32'(bus.commit_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Out-of-order writeback, in-order retirement
        do_reset();
        for (int i = 0; i < 3; i++) begin issue(T_R, 5'(5 + i), 1'b0, 32'h0); cycle(); end
        chk("model_tail_ooo", 32'(m_tail), 32'd3);
        wb_rs(2, 32'h22);  cycle();
        wb_rs(0, 32'h10);  cycle();
        wb_lsb(1, 32'h11); cycle();
        repeat (4) cycle();
        chk("ooo_count", 32'(dlog.size()), 32'd3);
        if (dlog.size() == 3) begin
            chk("ooo_id0", 32'(dlog[0].id), 32'd0);  chk("ooo_val0", dlog[0].val, 32'h10);
            chk("ooo_rd0", 32'(dlog[0].rd), 32'd5);
            chk("ooo_id1", 32'(dlog[1].id), 32'd1);  chk("ooo_val1", dlog[1].val, 32'h11);
            chk("ooo_id2", 32'(dlog[2].id), 32'd2);  chk("ooo_val2", dlog[2].val, 32'h22);
            chk("ooo_rd2", 32'(dlog[2].rd), 32'd7);
        end

        // Full, ignored ninth issue, wrap to id 0
        do_reset();
        for (int i = 0; i < 8; i++) begin issue(T_I, 5'(i + 1), 1'b0, 32'h0); cycle(); end
        chk("full_set", 32'(bus.rob_full), 32'd1);
        chk("full_tail", 32'(bus.tail_rob_id), 32'd0);
        issue(T_R, 5'd20, 1'b0, 32'h0); cycle();
        chk("full_ignored_tail", 32'(bus.tail_rob_id), 32'd0);
        chk("model_full_live", 32'(mq.size()), 32'd8);
        wb_rs(0, 32'hA0); cycle();
        cycle();
        chk("wrap_not_full", 32'(bus.rob_full), 32'd0);
        chk("wrap_next_id", 32'(bus.tail_rob_id), 32'd0);
        issue(T_R, 5'd21, 1'b0, 32'h0); cycle();
        chk("wrap_full_again", 32'(bus.rob_full), 32'd1);
        chk("wrap_tail", 32'(bus.tail_rob_id), 32'd1);

        // Same-cycle operand forwarding
        do_reset();
        for (int i = 0; i < 4; i++) begin issue(T_R, 5'(i + 1), 1'b0, 32'h0); cycle(); end
        bus.query1_id = 3'd3;
        #1 chk("fwd_not_ready", 32'(bus.query1_ready), 32'd0);
        wb_rs(3, 32'hDEAD);
        #1 chk("fwd_rs_ready", 32'(bus.query1_ready), 32'd1);
        chk("fwd_rs_value", bus.query1_value, 32'hDEAD);
        bus.query2_id = 3'd3;
        wb_lsb(3, 32'hBEEF);
        #1 chk("fwd_lsb_prio", bus.query2_value, 32'hBEEF);
        cycle();
        bus.query1_id = 3'd3;
        #1 chk("fwd_stored", bus.query1_value, 32'hBEEF);
        cycle();

        // Branch mispredict flush
        do_reset();
        issue(T_B, 5'd9, 1'b1, 32'h1004); cycle();
        issue(T_R, 5'd10, 1'b0, 32'h0); cycle();
        issue(T_R, 5'd11, 1'b0, 32'h0); wb_rs(1, 32'h5); cycle();
        wb_rs(0, 32'h0); wb_lsb(2, 32'h6); cycle();
        issue(T_R, 5'd12, 1'b0, 32'h0); cycle();
        repeat (3) cycle();
        chk("mis_commits", 32'(dlog.size()), 32'd1);
        if (dlog.size() > 0) begin
            chk("mis_id", 32'(dlog[0].id), 32'd0);
            chk("mis_rd", 32'(dlog[0].rd), 32'd0);
            chk("mis_clear", 32'(dlog[0].clr), 32'd1);
            chk("mis_redirect", dlog[0].rpc, 32'h1004);
        end
        chk("mis_tail", 32'(bus.tail_rob_id), 32'd0);
        issue(T_R, 5'd13, 1'b0, 32'h0); cycle();
        chk("mis_next_tail", 32'(bus.tail_rob_id), 32'd1);

        // rdy stall holds a ready head
        do_reset();
        issue(T_S, 5'd3, 1'b0, 32'h0); cycle();
        rdy = 1'b0;
        repeat (3) cycle();
        chk("stall_no_commit", 32'(dlog.size()), 32'd0);
        rdy = 1'b1;
        cycle();
        cycle();
        chk("stall_commit", 32'(dlog.size()), 32'd1);
        if (dlog.size() > 0) begin
            chk("stall_store", 32'(dlog[0].store), 32'd1);
            chk("stall_rd", 32'(dlog[0].rd), 32'd0);
        end

        // Asynchronous reset with five busy entries and a live commit pulse
        do_reset();
        for (int i = 0; i < 5; i++) begin issue(T_R, 5'(i + 1), 1'b0, 32'h0); cycle(); end
        issue(T_S, 5'd0, 1'b0, 32'h0); wb_rs(0, 32'h77); cycle();
        cycle();
        chk("pre_rst_live", 32'(mq.size()), 32'd5);
        #1 chk("pre_rst_cv", 32'(bus.commit_valid), 32'd1);
        chk("pre_rst_tail", 32'(bus.tail_rob_id), 32'd6);
        #1 rst = 1'b0;
        #1 chk("async_cv", 32'(bus.commit_valid), 32'd0);
        chk("async_full", 32'(bus.rob_full), 32'd0);
        chk("async_tail", 32'(bus.tail_rob_id), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 6) begin
                case ($urandom_range(0, 4))
                    0:       issue(T_R, 5'($urandom_range(0, 31)), 1'b0, $urandom);
                    1:       issue(T_I, 5'($urandom_range(0, 31)), 1'b0, $urandom);
                    2:       issue(T_S, 5'($urandom_range(0, 31)), 1'b0, $urandom);
                    3:       issue(T_B, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
                    default: issue(T_L, 5'($urandom_range(0, 31)), 1'b0, $urandom);
                endcase
            end
            if ($urandom_range(0, 1) == 1 && mq.size() > 0)
                wb_rs(mq[$urandom_range(0, mq.size() - 1)].id, $urandom);
            else if ($urandom_range(0, 7) == 0)
                wb_rs(int'($urandom_range(0, DEPTH - 1)), $urandom);
            if ($urandom_range(0, 2) == 0 && mq.size() > 0)
                wb_lsb(mq[$urandom_range(0, mq.size() - 1)].id, $urandom);
            cycle();
        end
        rdy = 1'b1;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
